race_progress_sequencer: RTL
============================

// Module: race_progress_sequencer
// PURPOSE
//  Per-frame race sequencer that feeds the progress-bar sprite controller.
//  Runs the race phase FSM: idle, 3-2-1 countdown, racing, paused, finished.
//  Integrates player speed into distance_drove once per frame and handles the crash stall.
//  Drives distance_drove, track_length and a pre-computed bar y-position to the progress bar / HUD.
// PARAMETERS
//  TRACK_LENGTH     53248  distance units to finish (= PB_Y_BOTTOM << DIST_SHIFT)
//  COUNTDOWN_FRAMES 180    frames spent in COUNTDOWN (60 per digit)
//  CRASH_FRAMES     90     frames of zero progress after a crash pulse
//  PB_Y_BOTTOM      416    bar y at distance 0 (pixels)
//  DIST_SHIFT       7      distance-to-pixel divide, as a right shift
// PORTS
//  clk              in   1   system clock
//  reset            in   1   synchronous, active-high reset
//  frame_start      in   1   1-cycle pulse, once per video frame
//  start_req        in   1   1-cycle pulse from game logic / key
//  pause_req        in   1   1-cycle pulse, toggles RACING<->PAUSED
//  crash            in   1   1-cycle pulse from car collision logic
//  speed            in   5   distance units per frame (0..31)
//  race_state       out  3   0 IDLE,1 COUNTDOWN,2 RACING,3 PAUSED,4 FINISHED
//  countdown_digit  out  2   3/2/1 during COUNTDOWN, 0 otherwise
//  distance_drove   out  32  accumulated distance, saturates at TRACK_LENGTH
//  track_length     out  32  constant TRACK_LENGTH
//  pb_y             out  11  PB_Y_BOTTOM - (distance_drove >> DIST_SHIFT)
//  crashed          out  1   high while the crash timer is nonzero
//  race_done        out  1   1-cycle pulse on entry to FINISHED
// BEHAVIOUR
//  Reset values:
//   - race_state = IDLE; distance_drove = 0; pb_y = PB_Y_BOTTOM.
//   - countdown_digit = 0; crashed = 0; race_done = 0; all internal timers = 0.
//   - reset mid-race takes effect on the next edge and overrides all other inputs.
//  FSM transitions (registered; each takes effect on the edge where its condition is sampled):
//   - IDLE: start_req -> COUNTDOWN, cd_cnt = COUNTDOWN_FRAMES-1.
//   - COUNTDOWN: on frame_start, cd_cnt decrements. On frame_start with cd_cnt==0 -> RACING.
//     countdown_digit = 3 - (elapsed/60), derived from the registered cd_cnt.
//     pause_req and crash are ignored.
//   - RACING: on frame_start, distance_drove += speed unless crashed.
//     The sum saturates at TRACK_LENGTH. Reaching TRACK_LENGTH -> FINISHED and race_done=1 for one cycle.
//   - RACING: pause_req -> PAUSED.
//   - PAUSED: no distance or timer updates. pause_req -> RACING.
//   - FINISHED: distance held. start_req -> COUNTDOWN with distance_drove=0, crash timer=0, cd_cnt reloaded.
//   - start_req is ignored in COUNTDOWN, RACING and PAUSED.
//  Crash handling:
//   - crash in RACING loads crash_cnt = CRASH_FRAMES; a re-crash reloads it.
//   - crash_cnt decrements on each RACING frame_start and is frozen in PAUSED.
//   - crashed = (crash_cnt != 0).
//  Simultaneous events:
//   - pause_req + frame_start in RACING: pause wins, no increment that frame.
//   - crash + frame_start in RACING: the crash timer loads and no increment that frame.
//   - crash + pause_req: both act; the timer loads and the state becomes PAUSED.
//   - finishing frame + pause_req: FINISHED wins.
//  Latency:
//   - distance_drove is valid 1 cycle after frame_start.
//   - pb_y is registered from distance_drove, so it is valid 2 cycles after frame_start.
//     This is well inside the blanking period.
//  Arithmetic:
//   - the add is done in 33 bits before the saturate compare; no wrap is possible.
//   - pb_y never drops below PB_Y_BOTTOM - (TRACK_LENGTH >> DIST_SHIFT), which is 0 at defaults.
// TESTING
//  1. reset, start_req, 180 frame_starts -> countdown_digit 3,2,1 for 60 frames each; RACING after frame 180.
//  2. RACING, speed=16, 10 frames -> distance_drove=160; pb_y=415 two cycles after the last frame.
//  3. distance=53240, speed=31, frame_start -> distance=53248, FINISHED, race_done high exactly 1 cycle, pb_y=0.
//  4. crash at distance 100, speed=10, 90 frames -> distance stays 100 and crashed falls.
//     Frame 91 -> distance 110.
//  5. pause_req + frame_start in the same cycle -> PAUSED, no increment.
//     Frames while PAUSED -> no change. Second pause_req -> RACING.
//  6. reset asserted mid-RACING at distance 5000 -> next cycle IDLE, distance 0, pb_y 416.
//     start_req in RACING (before reset) -> ignored.

Source files
------------

// File: rtl/race_progress_sequencer.sv
// Race phase sequencer: countdown, racing, pause, finish and crash stall.
// Ports: clk, reset, frame_start, start_req, pause_req, crash, speed in;
//        race_state, countdown_digit, distance_drove, track_length, pb_y,
//        crashed, race_done out. Per-frame distance feeds the progress bar.
module race_progress_sequencer #(
    parameter int unsigned TRACK_LENGTH     = 53248,
    parameter int unsigned COUNTDOWN_FRAMES = 180,
    parameter int unsigned CRASH_FRAMES     = 90,
    parameter int unsigned PB_Y_BOTTOM      = 416,
    parameter int unsigned DIST_SHIFT       = 7
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        frame_start,
    input  logic        start_req,
    input  logic        pause_req,
    input  logic        crash,
    input  logic [4:0]  speed,
    output logic [2:0]  race_state,
    output logic [1:0]  countdown_digit,
    output logic [31:0] distance_drove,
    output logic [31:0] track_length,
    output logic [10:0] pb_y,
    output logic        crashed,
    output logic        race_done
);

    localparam int unsigned CD_W  = $clog2(COUNTDOWN_FRAMES);
    localparam int unsigned CR_W  = $clog2(CRASH_FRAMES + 1);
    localparam int unsigned DIGIT = COUNTDOWN_FRAMES / 3;

    localparam logic [CD_W-1:0] CD_LOAD = CD_W'(COUNTDOWN_FRAMES - 1);
    localparam logic [CD_W-1:0] CD_HI   = CD_W'(2 * DIGIT);
    localparam logic [CD_W-1:0] CD_MID  = CD_W'(DIGIT);
    localparam logic [CR_W-1:0] CR_LOAD = CR_W'(CRASH_FRAMES);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_COUNTDOWN = 3'd1,
        S_RACING    = 3'd2,
        S_PAUSED    = 3'd3,
        S_FINISHED  = 3'd4
    } state_t;

    state_t          state_q, state_d;
    logic [CD_W-1:0] cd_q, cd_d;
    logic [CR_W-1:0] crash_q, crash_d;
    logic [31:0]     dist_q, dist_d;
    logic            done_q, done_d;
    logic [10:0]     pb_q;
    logic [32:0]     sum;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            cd_q    <= '0;
            crash_q <= '0;
            dist_q  <= '0;
            done_q  <= 1'b0;
            pb_q    <= 11'(PB_Y_BOTTOM);
        end else begin
            state_q <= state_d;
            cd_q    <= cd_d;
            crash_q <= crash_d;
            dist_q  <= dist_d;
            done_q  <= done_d;
            // Registered from the already-updated distance: one extra cycle.
            pb_q    <= 11'(PB_Y_BOTTOM) - dist_q[DIST_SHIFT +: 11];
        end
    end

    always_comb begin
        state_d = state_q;
        cd_d    = cd_q;
        crash_d = crash_q;
        dist_d  = dist_q;
        done_d  = 1'b0;
        // 33-bit add so the saturate compare can never see a wrapped value.
        sum     = {1'b0, dist_q} + {28'd0, speed};
        case (state_q)
            S_IDLE: begin
                if (start_req) begin
                    state_d = S_COUNTDOWN;
                    cd_d    = CD_LOAD;
                end
            end
            S_COUNTDOWN: begin
                if (frame_start) begin
                    if (cd_q == '0) state_d = S_RACING;
                    else            cd_d    = cd_q - 1'b1;
                end
            end
            S_RACING: begin
                // Priority: crash, crash stall, finishing frame, pause, move.
                if (crash) begin
                    crash_d = CR_LOAD;
                    if (pause_req) state_d = S_PAUSED;
                end else if (frame_start && crash_q != '0) begin
                    if (pause_req) state_d = S_PAUSED;
                    else           crash_d = crash_q - 1'b1;
                end else if (frame_start && sum >= 33'(TRACK_LENGTH)) begin
                    dist_d  = TRACK_LENGTH;
                    state_d = S_FINISHED;
                    done_d  = 1'b1;
                end else if (pause_req) begin
                    state_d = S_PAUSED;
                end else if (frame_start) begin
                    dist_d = sum[31:0];
                end
            end
            S_PAUSED: begin
                if (pause_req) state_d = S_RACING;
            end
            S_FINISHED: begin
                if (start_req) begin
                    state_d = S_COUNTDOWN;
                    cd_d    = CD_LOAD;
                    dist_d  = '0;
                    crash_d = '0;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Digit = 3 - elapsed/DIGIT, with elapsed = CD_LOAD - cd_q.
    always_comb begin
        countdown_digit = 2'd0;
        if (state_q == S_COUNTDOWN) begin
            if (cd_q >= CD_HI)       countdown_digit = 2'd3;
            else if (cd_q >= CD_MID) countdown_digit = 2'd2;
            else                     countdown_digit = 2'd1;
        end
    end

    assign race_state     = state_q;
    assign distance_drove = dist_q;
    assign track_length   = TRACK_LENGTH;
    assign pb_y           = pb_q;
    assign crashed        = (crash_q != '0);
    assign race_done      = done_q;

endmodule
